mux_nto1_pipe: RTL and testbench

//   Parametrised N-input, W-bit selector with a registered, flow-controlled output.

---
 rtl/mux_nto1_pipe.sv | 152 +++++++++++++++
 tb/tb_mux_nto1_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// NUM_IN-input, WIDTH-bit selector feeding a 2-entry valid/ready output buffer.
// Optional round-robin channel choice is enabled by defining MUX_RR_ARB_EN.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    rr_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (SEL_W != $clog2(NUM_IN)) begin : g_bad_sel_w
    $error("mux_nto1_pipe: SEL_W must equal $clog2(NUM_IN)");
  end
  if (NUM_IN < 2) begin : g_bad_num_in
    $error("mux_nto1_pipe: NUM_IN must be at least 2");
  end

  logic [SEL_W-1:0] chan;
  logic             chan_ok;
  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_vld_p0;
  logic             full;
  logic             push;
  logic             pop;

  logic [1:0]       count_p1;
  logic [WIDTH-1:0] hd_data_p1;
  logic [SEL_W-1:0] hd_src_p1;
  logic [WIDTH-1:0] tl_data_p1;
  logic [SEL_W-1:0] tl_src_p1;

`ifdef MUX_RR_ARB_EN
  logic [SEL_W-1:0] ptr_p1;
  logic [SEL_W-1:0] rr_chan;
  int               rr_best;
  int               rr_dist;
  int               ptr_nxt;

  // Pick the valid channel closest to ptr going upward (with wrap).
  always_comb begin
    rr_chan = ptr_p1;
    rr_best = NUM_IN;
    rr_dist = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      rr_dist = i - int'(ptr_p1);
      if (rr_dist < 0) rr_dist = rr_dist + NUM_IN;
      if (in_valid[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_chan = SEL_W'(i);
      end
    end
  end

  always_comb begin
    ptr_nxt = int'(chan) + 1;
    if (ptr_nxt >= NUM_IN) ptr_nxt = 0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_p1 <= '0;
    end else if (push && rr_mode) begin
      ptr_p1 <= SEL_W'(ptr_nxt);
    end
  end

  always_comb begin
    chan    = sel;
    chan_ok = int'(sel) < NUM_IN;
    if (rr_mode) begin
      chan    = rr_chan;
      chan_ok = 1'b1;
    end
  end
`else
  logic rr_mode_unused;
  assign rr_mode_unused = rr_mode;

  always_comb begin
    chan    = sel;
    chan_ok = int'(sel) < NUM_IN;
  end
`endif

  // Stage p0: combinational channel select and handshake
  always_comb begin
    sel_data_p0 = '0;
    sel_vld_p0  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (chan_ok && (int'(chan) == i)) begin
        sel_data_p0 = in_data[i*WIDTH +: WIDTH];
        sel_vld_p0  = in_valid[i];
      end
    end
  end

  assign full = (count_p1 == 2'd2);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = rst_n && chan_ok && (int'(chan) == i) && !full;
    end
  end

  assign push      = sel_vld_p0 && chan_ok && !full;
  assign out_valid = (count_p1 != 2'd0);
  assign pop       = out_valid && out_ready;

  // Stage p1: two-entry output buffer, head drives the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1   <= 2'd0;
      hd_data_p1 <= '0;
      hd_src_p1  <= '0;
    end else begin
      if (push && !pop) begin
        count_p1 <= count_p1 + 2'd1;
      end else if (!push && pop) begin
        count_p1 <= count_p1 - 2'd1;
      end
      if (push && ((count_p1 == 2'd0) || ((count_p1 == 2'd1) && pop))) begin
        hd_data_p1 <= sel_data_p0;
        hd_src_p1  <= chan;
      end else if (pop && (count_p1 == 2'd2)) begin
        hd_data_p1 <= tl_data_p1;
        hd_src_p1  <= tl_src_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop && (count_p1 == 2'd1)) begin
      tl_data_p1 <= sel_data_p0;
      tl_src_p1  <= chan;
    end
  end

  assign out_data = hd_data_p1;
  assign out_src  = hd_src_p1;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: per-cycle scoreboard checker plus table rows and hand sequences.
// Round-robin sequences are exercised only when MUX_RR_ARB_EN is defined.
module tb_mux_nto1_pipe;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [SW-1:0] sel = '0;
  logic          rr_mode = 1'b0;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_valid;
  logic          out_ready = 1'b0;

  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3 = '0;
  logic           rr3 = 1'b0;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_src3;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_pipe #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .rr_mode(rr3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } exp_t;
  exp_t q[$];
  logic [SW-1:0] mptr = '0;

  typedef struct {
    logic [SW-1:0] sel;
    logic [N-1:0]  vld;
    logic          rr;
    int            ordy;   // 0 low, 1 high, 2 random
    int            cyc;
  } vec_t;
  vec_t vecs[8];
  int   ordy_mode = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void pick(output logic ok, output int c);
    c  = int'(sel);
    ok = int'(sel) < N;
`ifdef MUX_RR_ARB_EN
    if (rr_mode) begin
      ok = 1'b1;
      c  = int'(mptr);
      for (int k = 0; k < N; k++) begin
        int i;
        i = (int'(mptr) + k) % N;
        if (in_valid[i]) begin
          c = i;
          break;
        end
      end
    end
`endif
  endfunction

  // Scoreboard: inputs are stable from posedge+1 through the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        mptr = '0;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
      end else begin
        logic          ok;
        int            c;
        logic [SW-1:0] ci;
        logic [N-1:0]  exp_rdy;
        logic          psh;
        logic          pp;
        pick(ok, c);
        ci = SW'(c);
        exp_rdy = '0;
        if (ok && (q.size() < 2)) exp_rdy[ci] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
          chk("out_data", 64'(out_data), 64'(q[0].d));
          chk("out_src", 64'(out_src), 64'(q[0].s));
        end
        pp  = (q.size() != 0) && out_ready;
        psh = exp_rdy[ci] && in_valid[ci];
        if (pp) void'(q.pop_front());
        if (psh) begin
          q.push_back({in_data[c*W +: W], ci});
          if (rr_mode) mptr = SW'((c + 1) % N);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_data3 = {$urandom, $urandom, $urandom};
    if (ordy_mode == 0) out_ready = 1'b0;
    else if (ordy_mode == 1) out_ready = 1'b1;
    else out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [W-1:0] w3;
    vecs[0] = '{2'd0, 4'b0001, 1'b0, 1, 6};
    vecs[1] = '{2'd3, 4'b1000, 1'b0, 2, 10};
    vecs[2] = '{2'd1, 4'b1101, 1'b0, 1, 4};
    vecs[3] = '{2'd2, 4'b1111, 1'b0, 0, 4};
    vecs[4] = '{2'd2, 4'b1111, 1'b0, 2, 10};
    vecs[5] = '{2'd0, 4'b1110, 1'b1, 1, 6};
    vecs[6] = '{2'd1, 4'b0011, 1'b0, 2, 12};
    vecs[7] = '{2'd3, 4'b1111, 1'b0, 1, 6};

    // Reset with every channel offering
    #1 rst_n = 1'b0;
    in_valid = 4'hF;
    sel = 2'd2;
    #2;
    chk("t1_in_ready", 64'(in_ready), 64'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_out_data", 64'(out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 4'b0000;
    #1 chk("t1_release_ready", 64'(in_ready), 64'b0100);

    // Single-cycle latency and sustained throughput on channel 2
    ordy_mode = 1;
    out_ready = 1'b1;
    in_valid = 4'b0100;
    in_data[2*W +: W] = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("t2_out_data", 64'(out_data), 64'hDEADBEEF);
    chk("t2_out_src", 64'(out_src), 64'd2);
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_sustain_valid", 64'(out_valid), 64'd1);
      chk("t2_sustain_ready", 64'(in_ready), 64'b0100);
    end

    // Backpressure: third word waits until a slot frees
    in_valid = 4'b0000;
    step();
    ordy_mode = 0;
    out_ready = 1'b0;
    sel = 2'd1;
    in_valid = 4'b0010;
    step();
    chk("t3_ready_cnt1", 64'(in_ready), 64'b0010);
    step();
    chk("t3_ready_full", 64'(in_ready), 64'd0);
    chk("t3_valid_full", 64'(out_valid), 64'd1);
    step();
    chk("t3_ready_stall", 64'(in_ready), 64'd0);
    ordy_mode = 1;
    out_ready = 1'b1;
    step();
    chk("t3_ready_freed", 64'(in_ready), 64'b0010);
    in_valid = 4'b0000;
    repeat (3) step();

    // Table rows
    for (int r = 0; r < 8; r++) begin
      sel       = vecs[r].sel;
      in_valid  = vecs[r].vld;
      rr_mode   = vecs[r].rr;
      ordy_mode = vecs[r].ordy;
      for (int k = 0; k < vecs[r].cyc; k++) step();
    end
    rr_mode = 1'b0;
    in_valid = '0;
    ordy_mode = 1;
    repeat (3) step();

    // Three-input instance: out-of-range select chooses nothing
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_in_ready3", 64'(in_ready3), 64'd0);
      chk("t4_out_valid3", 64'(out_valid3), 64'd0);
    end
    sel3 = 2'd2;
    in_valid3 = 3'b100;
    w3 = in_data3[2*W +: W];
    #1 chk("t4_sel2_ready", 64'(in_ready3), 64'b100);
    @(posedge clk);
    #1;
    chk("t4_sel2_valid", 64'(out_valid3), 64'd1);
    chk("t4_sel2_src", 64'(out_src3), 64'd2);
    chk("t4_sel2_data", 64'(out_data3), 64'(w3));
    in_valid3 = 3'b000;
    step();

    // Async reset while the buffer is full
    ordy_mode = 0;
    out_ready = 1'b0;
    sel = 2'd3;
    in_valid = 4'b1000;
    repeat (3) step();
    chk("t6_full_before", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_ready", 64'(in_ready), 64'd0);
    chk("t6_async_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = '0;
    ordy_mode = 1;
    out_ready = 1'b1;
    #1 chk("t6_after_ready", 64'(in_ready), 64'b1000);

`ifdef MUX_RR_ARB_EN
    // Round-robin rotation from the reset pointer
    rr_mode = 1'b1;
    in_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t5_rr_all", 64'(out_src), 64'(k % 4));
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_rr_13", 64'(out_src), (k % 2 == 0) ? 64'd1 : 64'd3);
    end
    in_valid = '0;
    rr_mode = 1'b0;
`endif

    repeat (3) step();
    chk("drain_empty", 64'(out_valid), 64'd0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
